// File: rtl/datapath_pkg.sv
// Shared op-codes, flag bit positions and multiply-sequencer state encodings
// for the pipelined register-file/ALU datapath.
package datapath_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_NOT   = 4'd5;
    localparam logic [3:0] OP_SHL   = 4'd6;
    localparam logic [3:0] OP_SHR   = 4'd7;
    localparam logic [3:0] OP_PASSA = 4'd8;
    localparam logic [3:0] OP_PASSB = 4'd9;
    localparam logic [3:0] OP_INC   = 4'd10;
    localparam logic [3:0] OP_DEC   = 4'd11;
    localparam logic [3:0] OP_MUL   = 4'd12;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mulState_t;

endpackage

// File: rtl/datapath_if.sv
// Issue/result bundle of the pipelined datapath; the master drives instructions,
// the slave (datapath) returns handshake, results and status.
interface datapath_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
);
    logic             issueValid;
    logic             issueReady;
    logic             writeEnable;
    logic             writeSourceSelect;
    logic             muxASelect;
    logic             muxBSelect;
    logic [WIDTH-1:0] extInputData;
    logic [AW-1:0]    destAddress;
    logic [AW-1:0]    aAddress;
    logic [AW-1:0]    bAddress;
    logic [3:0]       aluOpCode;
    logic             resultValid;
    logic [WIDTH-1:0] resultData;
    logic [2:0]       flags;
    logic [WIDTH-1:0] rTop_out;

    modport master (
        output issueValid, writeEnable, writeSourceSelect, muxASelect, muxBSelect,
               extInputData, destAddress, aAddress, bAddress, aluOpCode,
        input  issueReady, resultValid, resultData, flags, rTop_out
    );

    modport slave (
        input  issueValid, writeEnable, writeSourceSelect, muxASelect, muxBSelect,
               extInputData, destAddress, aAddress, bAddress, aluOpCode,
        output issueReady, resultValid, resultData, flags, rTop_out
    );
endinterface

// File: rtl/datapath_pipe_alu.sv
// Combinational single-cycle ALU with {N,C,Z} generation; the multiply result
// is produced by the iterative sequencer and only muxed in here.
module alu_param
    import datapath_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       opCode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] mulLo,
    input  logic             mulHiNonZero,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flagsOut
);
    logic             carry;
    logic [WIDTH:0]   wide;

    always_comb begin
        result = '0;
        carry  = 1'b0;
        wide   = '0;
        case (opCode)
            OP_ADD:   begin wide = {1'b0, a} + {1'b0, b}; result = wide[WIDTH-1:0]; carry = wide[WIDTH]; end
            OP_SUB:   begin wide = {1'b0, a} - {1'b0, b}; result = wide[WIDTH-1:0]; carry = wide[WIDTH]; end
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_NOT:   result = ~a;
            OP_SHL:   begin result = {a[WIDTH-2:0], 1'b0}; carry = a[WIDTH-1]; end
            OP_SHR:   begin result = {1'b0, a[WIDTH-1:1]}; carry = a[0]; end
            OP_PASSA: result = a;
            OP_PASSB: result = b;
            OP_INC:   begin wide = {1'b0, a} + (WIDTH+1)'(1); result = wide[WIDTH-1:0]; carry = wide[WIDTH]; end
            OP_DEC:   begin wide = {1'b0, a} - (WIDTH+1)'(1); result = wide[WIDTH-1:0]; carry = wide[WIDTH]; end
            OP_MUL:   begin result = mulLo; carry = mulHiNonZero; end
            default:  ;
        endcase
        flagsOut         = '0;
        flagsOut[FLAG_Z] = (result == '0);
        flagsOut[FLAG_C] = carry;
        flagsOut[FLAG_N] = result[WIDTH-1];
    end
endmodule

// File: rtl/datapath_pipe.sv
// Two-stage datapath: issue selects/forwards operands into the EX register,
// execute computes, writes back and reports; MUL stalls issue for WIDTH cycles.
//
// state    | meaning
// MUL_IDLE | single-cycle ops flow, issueReady=1
// MUL_BUSY | shift-add multiply iterating, issue stalled
module datapath_pipe
    import datapath_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 16,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic    clk,
    input  logic    reset,
    datapath_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]   regFile [NREGS];
    logic               exValid, exWe, exWsel;
    logic [3:0]         exOp;
    logic [WIDTH-1:0]   exA, exB, exExt;
    logic [AW-1:0]      exDest;
    logic               resultValidReg;
    logic [WIDTH-1:0]   resultDataReg;
    logic [2:0]         flagsReg;

    mulState_t          mulState, mulNext;
    logic [CW-1:0]      mulCnt;
    logic [2*WIDTH-1:0] mulAcc, mulCand, mulProd;
    logic [WIDTH-1:0]   mulPlier;

    logic               accept, mulLast, done, wbWrite;
    logic [WIDTH-1:0]   aluResult, wbData, opA, opB;
    logic [2:0]         aluFlags;

    assign accept  = bus.issueValid && bus.issueReady;
    assign mulLast = (mulState == MUL_BUSY) && (mulCnt == CW'(1));
    assign done    = (exValid && (exOp != OP_MUL)) || mulLast;
    // Final shift-add step is folded into the completion edge.
    assign mulProd = mulAcc + (mulPlier[0] ? mulCand : '0);
    assign wbData  = exWsel ? exExt : aluResult;
    assign wbWrite = done && exWe;

    alu_param #(.WIDTH(WIDTH)) u_alu (
        .opCode       (exOp),
        .a            (exA),
        .b            (exB),
        .mulLo        (mulProd[WIDTH-1:0]),
        .mulHiNonZero (|mulProd[2*WIDTH-1:WIDTH]),
        .result       (aluResult),
        .flagsOut     (aluFlags)
    );

    always_comb begin
        opA = regFile[bus.aAddress];
        opB = regFile[bus.bAddress];
        if (wbWrite && (exDest == bus.aAddress)) opA = wbData;
        if (wbWrite && (exDest == bus.bAddress)) opB = wbData;
        if (bus.muxASelect) opA = bus.extInputData;
        if (bus.muxBSelect) opB = bus.extInputData;
    end

    always_comb begin
        mulNext = mulState;
        case (mulState)
            MUL_IDLE: if (accept && (bus.aluOpCode == OP_MUL)) mulNext = MUL_BUSY;
            MUL_BUSY: if (mulCnt == CW'(1)) mulNext = MUL_IDLE;
            default:  mulNext = MUL_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) mulState <= MUL_IDLE;
        else       mulState <= mulNext;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regFile[i] <= '0;
            exValid        <= 1'b0;
            exWe           <= 1'b0;
            exWsel         <= 1'b0;
            exOp           <= '0;
            exA            <= '0;
            exB            <= '0;
            exExt          <= '0;
            exDest         <= '0;
            mulCnt         <= '0;
            mulAcc         <= '0;
            mulCand        <= '0;
            mulPlier       <= '0;
            resultValidReg <= 1'b0;
            resultDataReg  <= '0;
            flagsReg       <= '0;
        end else begin
            exValid <= accept;
            if (accept) begin
                exOp   <= bus.aluOpCode;
                exA    <= opA;
                exB    <= opB;
                exExt  <= bus.extInputData;
                exDest <= bus.destAddress;
                exWe   <= bus.writeEnable;
                exWsel <= bus.writeSourceSelect;
            end
            if (accept && (bus.aluOpCode == OP_MUL)) begin
                mulAcc   <= '0;
                mulCand  <= {{WIDTH{1'b0}}, opA};
                mulPlier <= opB;
                mulCnt   <= CW'(WIDTH);
            end else if (mulState == MUL_BUSY) begin
                mulAcc   <= mulProd;
                mulCand  <= mulCand << 1;
                mulPlier <= mulPlier >> 1;
                mulCnt   <= mulCnt - CW'(1);
            end
            resultValidReg <= done;
            if (done) resultDataReg <= wbData;
            if (done && !exWsel) flagsReg <= aluFlags;
            if (wbWrite) regFile[exDest] <= wbData;
        end
    end

    assign bus.issueReady  = (mulState == MUL_IDLE);
    assign bus.resultValid = resultValidReg;
    assign bus.resultData  = resultDataReg;
    assign bus.flags       = flagsReg;
    assign bus.rTop_out    = regFile[NREGS-1];
endmodule

// File: doc/datapath_pipe.md
Name: datapath_pipe

Overview:
- Parametrised, two-stage pipelined successor to the single-cycle register-file/ALU datapath.
- Stage 1 (issue) selects operands from the register file, the external input or the forwarding path, then registers them.
- Stage 2 (execute) computes the ALU result, updates the status flags and writes back.
- Adds a valid/ready issue handshake, a status-flag register, an observable result port and a multi-cycle iterative multiply that stalls issue.

Parameters:
- WIDTH, 8: data width of registers, ALU and external input.
- NREGS, 16: number of registers; power of two, at least 2.
- AW, $clog2(NREGS): register address width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- issueValid  in  1  instruction fields below are valid this cycle.
- issueReady  out  1  datapath accepts an instruction this cycle.
- writeEnable  in  1  instruction writes destAddress at writeback.
- writeSourceSelect  in  1  1 = write extInputData, 0 = write ALU result.
- muxASelect  in  1  1 = ALU A is extInputData, 0 = register A.
- muxBSelect  in  1  1 = ALU B is extInputData, 0 = register B.
- extInputData  in  WIDTH  immediate / external data.
- destAddress  in  AW  writeback register.
- aAddress  in  AW  register A read address.
- bAddress  in  AW  register B read address.
- aluOpCode  in  4  operation code.
- resultValid  out  1  one-cycle pulse: resultData holds a completed instruction.
- resultData  out  WIDTH  value of the last completed instruction (write data).
- flags  out  3  {N, C, Z} of the last completed ALU instruction.
- rTop_out  out  WIDTH  live value of register NREGS-1.

Behaviour:
- Reset (async): all registers 0, EX stage empty, multiply FSM IDLE; issueReady=1, resultValid=0, resultData=0, flags=0.
- Accept: an instruction is taken on a rising edge where issueValid && issueReady. Operands, op, dest, writeEnable and writeSourceSelect are captured into the EX register.
- Operand selection: the external input wins if its mux select is 1. Otherwise, if the EX stage is completing a write this same edge to a matching address, the forwarded EX write data is used. Otherwise the register-file value is used.
- Single-cycle op latency: accepted at edge N, completed at edge N+1. Then the register is written (if writeEnable), resultData and flags are updated, and resultValid=1 for one cycle.
- Write data is extInputData if writeSourceSelect=1, else the ALU result.
- Flags update only when writeSourceSelect=0, whether or not writeEnable is set.
- Ops, modulo 2^WIDTH:
  - 0 ADD (C = carry-out)
  - 1 SUB A-B (C = borrow)
  - 2 AND, 3 OR, 4 XOR
  - 5 NOT A
  - 6 SHL A by 1 (C = old msb)
  - 7 SHR A by 1 (C = old lsb)
  - 8 PASS A, 9 PASS B
  - 10 INC A, 11 DEC A (C = carry/borrow)
  - 12 MUL, low WIDTH bits of A*B (C = high product non-zero)
  - 13-15 result 0, C=0
  - Non-arithmetic ops clear C.
  - Z = (result==0); N = result msb.
- MUL FSM:
  - IDLE -> MUL on accept of op 12; iterates one shift-add step per cycle for WIDTH cycles.
  - issueReady=0 from the accept edge until the completion edge. Completion is at edge N+WIDTH; writeback, resultValid and flags follow the single-cycle rules.
  - Returns to IDLE on the completion edge; issueReady=1 in the following cycle.
- Back-to-back issue: single-cycle ops sustain one instruction per cycle with full forwarding; no bubbles.
- Register NREGS-1 is an ordinary register; rTop_out reflects its value after each write edge.
- Reset mid-MUL: aborts with no writeback; state returns to the reset values.
- issueValid=0 on an edge: no accept; the EX stage drains normally.

Decomposition:
- Shared package datapath_pkg holds:
  - the op-code localparams (OP_ADD..OP_MUL)
  - flag bit indices (FLAG_Z=0, FLAG_C=1, FLAG_N=2)
  - MUL FSM state encodings
- One sub-module: alu_param (WIDTH-parametrised, combinational single-cycle ops and flag generation).
- The register file, forwarding logic and MUL FSM stay in datapath_pipe.

Test Plan (WIDTH=8, NREGS=16):
- Reset mid-stream, then issue load R1=0x05 (writeSourceSelect=1, ext=0x05) -> next cycle resultValid=1, resultData=0x05, flags unchanged 0.
- R1=0x05, R2=0xFB, issue ADD R3=R1+R2 -> resultData=0x00, flags Z=1, C=1, N=0; R3=0x00.
- Back-to-back: load R4=0x10, then immediately SHL R5=R4 -> forwarding gives R5=0x20 with no stall; both resultValid pulses on consecutive cycles.
- MUL R15=R1*ext with ext=0x33 -> issueReady low for 8 cycles; completion gives rTop_out=0xFF, C=0, N=1; the next instruction is accepted the cycle after.
- MUL 0x20*0x10 -> result 0x00, Z=1, C=1; assert reset at cycle 4 of MUL -> no writeback, issueReady=1, all registers 0.
- SUB R6 = 0x03-0x04 -> 0xFF, C=1, N=1, Z=0; op 14 -> result 0, Z=1, C=0.
